player_move_sequencer: RTL and testbench

//  Sequences every move of the player rectangle. Once per tick it samples the buttons and
//  the per-direction enables, proposes a new position and handshakes with the collision

---
 rtl/player_move_sequencer.sv | 138 +++++++++++++
 tb/tb_player_move_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_sequencer.sv
// Player move sequencer: samples the buttons once per tick, proposes a one-step move,
// handshakes with the collision checker and either commits the move or pulses blocked.
module player_move_sequencer #(
  parameter int unsigned STEP         = 12,
  parameter int unsigned H_START      = 308,
  parameter int unsigned V_START      = 384,
  parameter int unsigned H_MIN        = 0,
  parameter int unsigned H_MAX        = 628,
  parameter int unsigned V_MIN        = 0,
  parameter int unsigned V_MAX        = 468,
  parameter int unsigned REPEAT_TICKS = 8,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        btnClk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  btns,
  input  logic        upEnable,
  input  logic        downEnable,
  input  logic        leftEnable,
  input  logic        rightEnable,
  output logic        chk_req,
  output logic [10:0] chk_hPos,
  output logic [10:0] chk_vPos,
  input  logic        chk_ack,
  input  logic        chk_clear,
  output logic [10:0] hPos,
  output logic [10:0] vPos,
  output logic [10:0] hOffset,
  output logic [10:0] vOffset,
  output logic        moving,
  output logic        blocked
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, COMMIT, HOLD} state_t;

  localparam logic [11:0] STEP12   = 12'(STEP);
  localparam logic [11:0] H_LOW12  = 12'(H_MIN + STEP);
  localparam logic [11:0] V_LOW12  = 12'(V_MIN + STEP);
  localparam logic [11:0] H_MAX12  = 12'(H_MAX);
  localparam logic [11:0] V_MAX12  = 12'(V_MAX);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [10:0] H_ORG11  = 11'(H_START);
  localparam logic [10:0] V_ORG11  = 11'(V_START);
  localparam logic [7:0]  ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  REP_LAST = 8'(REPEAT_TICKS - 1);

  state_t      state, stateNext;
  logic [7:0]  ackCnt, repCnt;
  logic [11:0] hExt, vExt;
  logic [10:0] propH, propV;
  logic        dirOk;
  logic        startMove, launch, reject, ackPass, ackFail, ackTimeout;
  logic        holdTick, repeatDone;

  assign hExt = {1'b0, hPos};
  assign vExt = {1'b0, vPos};

  // Priority up > down > left > right; bounds compared in 12 bits so +STEP cannot wrap.
  always_comb begin
    dirOk = 1'b0;
    propH = hPos;
    propV = vPos;
    if (btns[0]) begin
      dirOk = upEnable && (vExt >= V_LOW12);
      propV = vPos - STEP11;
    end else if (btns[1]) begin
      dirOk = downEnable && (vExt + STEP12 <= V_MAX12);
      propV = vPos + STEP11;
    end else if (btns[2]) begin
      dirOk = leftEnable && (hExt >= H_LOW12);
      propH = hPos - STEP11;
    end else if (btns[3]) begin
      dirOk = rightEnable && (hExt + STEP12 <= H_MAX12);
      propH = hPos + STEP11;
    end
  end

  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (launch) stateNext = WAIT_ACK;
                else if (reject) stateNext = HOLD;
      WAIT_ACK: if (ackPass) stateNext = COMMIT;
                else if (ackFail || ackTimeout) stateNext = HOLD;
      COMMIT:   stateNext = HOLD;
      HOLD:     if (btns == '0 || repeatDone) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_comb begin
    startMove  = (state == IDLE) && tick && (btns != '0);
    launch     = startMove && dirOk;
    reject     = startMove && !dirOk;
    ackPass    = (state == WAIT_ACK) && chk_ack && chk_clear;
    ackFail    = (state == WAIT_ACK) && chk_ack && !chk_clear;
    ackTimeout = (state == WAIT_ACK) && !chk_ack && (ackCnt == ACK_LAST);
    holdTick   = (state == HOLD) && (btns != '0) && tick;
    repeatDone = holdTick && (repCnt == REP_LAST);
    chk_req    = (state == WAIT_ACK);
    moving     = (state == COMMIT);
  end

  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) begin
      hPos     <= H_ORG11;
      vPos     <= V_ORG11;
      hOffset  <= '0;
      vOffset  <= '0;
      chk_hPos <= H_ORG11;
      chk_vPos <= V_ORG11;
      blocked  <= 1'b0;
      ackCnt   <= '0;
      repCnt   <= '0;
    end else begin
      blocked <= reject || ackFail || ackTimeout;
      if (launch) begin
        chk_hPos <= propH;
        chk_vPos <= propV;
      end
      if (state == WAIT_ACK) ackCnt <= ackCnt + 8'd1;
      else                   ackCnt <= '0;
      if (ackPass) begin
        hPos    <= chk_hPos;
        vPos    <= chk_vPos;
        hOffset <= chk_hPos - H_ORG11;
        vOffset <= chk_vPos - V_ORG11;
      end
      if (state != HOLD || btns == '0 || repeatDone) repCnt <= '0;
      else if (tick)                               repCnt <= repCnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_player_move_sequencer.sv
// Bench for player_move_sequencer: move-level reference model driven alongside random and
// directed stimulus, with a per-cycle comparison of every output.
module tb_player_move_sequencer;
  logic        btnClk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  btns = '0;
  logic        upEnable = 1'b1, downEnable = 1'b1, leftEnable = 1'b1, rightEnable = 1'b1;
  logic        chk_ack = 1'b0, chk_clear = 1'b0;
  logic        chk_req, moving, blocked;
  logic [10:0] chk_hPos, chk_vPos, hPos, vPos, hOffset, vOffset;

  logic [10:0] eH = 11'd308, eV = 11'd384, eCh = 11'd308, eCv = 11'd384;
  logic        eReq = 1'b0, eMov = 1'b0, eBlk = 1'b0;
  int          nChecks = 0, nFails = 0;
  int          moves, cnt;
  bit          idle, mv;

  always #5 btnClk = ~btnClk;

  player_move_sequencer dut (
    .btnClk(btnClk), .rst(rst), .tick(tick), .btns(btns),
    .upEnable(upEnable), .downEnable(downEnable), .leftEnable(leftEnable),
    .rightEnable(rightEnable), .chk_req(chk_req), .chk_hPos(chk_hPos),
    .chk_vPos(chk_vPos), .chk_ack(chk_ack), .chk_clear(chk_clear),
    .hPos(hPos), .vPos(vPos), .hOffset(hOffset), .vOffset(vOffset),
    .moving(moving), .blocked(blocked)
  );

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge btnClk) begin
    chk("hPos", hPos, eH);
    chk("vPos", vPos, eV);
    chk("hOffset", hOffset, eH - 11'd308);
    chk("vOffset", vOffset, eV - 11'd384);
    chk("chk_hPos", chk_hPos, eCh);
    chk("chk_vPos", chk_vPos, eCv);
    chk("chk_req", 11'(chk_req), 11'(eReq));
    chk("moving", 11'(moving), 11'(eMov));
    chk("blocked", 11'(blocked), 11'(eBlk));
  end

  task automatic cyc();
    @(posedge btnClk);
    #1;
    eMov = 1'b0;
    eBlk = 1'b0;
  endtask

  task automatic pad(input int n);
    repeat (n) cyc();
  endtask

  task automatic releaseBtns();
    btns = '0;
    cyc();
    cyc();
  endtask

  // One tick in IDLE; ack after 'delay' ack-free clocks (>=255 means never).
  task automatic tryMove(input logic [3:0] b, input logic [3:0] en, input int delay,
                         input bit clr, input bit noise, output bit moved);
    logic [10:0] th, tv;
    bit legal;
    th = eH;
    tv = eV;
    moved = 1'b0;
    if (b[0]) begin
      legal = en[0] && (int'(eV) - 12 >= 0);   tv = eV - 11'd12;
    end else if (b[1]) begin
      legal = en[1] && (int'(eV) + 12 <= 468); tv = eV + 11'd12;
    end else if (b[2]) begin
      legal = en[2] && (int'(eH) - 12 >= 0);   th = eH - 11'd12;
    end else begin
      legal = en[3] && (int'(eH) + 12 <= 628); th = eH + 11'd12;
    end
    btns = b;
    {rightEnable, leftEnable, downEnable, upEnable} = en;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    if (!legal) begin
      eBlk = 1'b1;
      return;
    end
    eReq = 1'b1;
    eCh = th;
    eCv = tv;
    for (int i = 1; i <= delay; i++) begin
      if (noise) begin
        btns = 4'($urandom);
        tick = 1'($urandom);
        {rightEnable, leftEnable, downEnable, upEnable} = 4'($urandom);
        chk_clear = 1'($urandom);
      end
      cyc();
      if (i == 255) begin
        eReq = 1'b0;
        eBlk = 1'b1;
        btns = b;
        tick = 1'b0;
        return;
      end
    end
    btns = b;
    chk_ack = 1'b1;
    chk_clear = clr;
    cyc();
    chk_ack = 1'b0;
    tick = 1'b0;
    eReq = 1'b0;
    if (clr) begin
      eH = th;
      eV = tv;
      eMov = 1'b1;
      moved = 1'b1;
    end else begin
      eBlk = 1'b1;
    end
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b1;

    // Idle ticks with no buttons change nothing.
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end

    tryMove(4'b0001, 4'hF, 3, 1'b1, 1'b0, mv);
    cyc();
    chk("lit vPos", vPos, 11'd372);
    chk("lit vOffset", vOffset, 11'h7F4);
    releaseBtns();

    tryMove(4'b1001, 4'b1110, 0, 1'b1, 1'b0, mv);
    releaseBtns();
    tryMove(4'b1000, 4'hF, 0, 1'b1, 1'b0, mv);
    cyc();
    chk("lit hPos", hPos, 11'd320);
    releaseBtns();

    // Timeout, ack in the expiring cycle, and a rejected ack.
    tryMove(4'b0010, 4'hF, 300, 1'b1, 1'b0, mv);
    releaseBtns();
    tryMove(4'b0010, 4'hF, 254, 1'b1, 1'b0, mv);
    releaseBtns();
    tryMove(4'b0001, 4'hF, 2, 1'b0, 1'b0, mv);
    releaseBtns();
    chk("lit vPos after aborts", vPos, 11'd384);

    // Held left button with ticks every 10 clocks.
    moves = 0; cnt = 0; idle = 1'b1;
    for (int s = 0; s < 30; s++) begin
      if (idle) begin
        tryMove(4'b0100, 4'hF, 1, 1'b1, 1'b0, mv);
        moves += int'(mv); idle = 1'b0; cnt = 0;
        pad(7);
      end else begin
        btns = 4'b0100; tick = 1'b1; cyc(); tick = 1'b0;
        cnt++;
        if (cnt == 8) idle = 1'b1;
        pad(9);
      end
    end
    chk("lit repeat moves", 11'(moves), 11'd4);
    chk("lit repeat hPos", hPos, 11'd272);
    releaseBtns();

    // Reset while waiting for the ack.
    btns = 4'b1000; tick = 1'b1; cyc(); tick = 1'b0;
    eReq = 1'b1; eCh = eH + 11'd12; eCv = eV;
    cyc(); cyc();
    rst = 1'b0;
    eReq = 1'b0; eH = 11'd308; eV = 11'd384; eCh = 11'd308; eCv = 11'd384;
    #1;
    chk("rst chk_req", 11'(chk_req), 11'd0);
    chk("rst hPos", hPos, 11'd308);
    btns = '0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Walk to every edge of the field and push against it.
    while (int'(eV) >= 12) begin tryMove(4'b0001, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns(); end
    tryMove(4'b0001, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns();
    while (int'(eV) + 12 <= 468) begin tryMove(4'b0010, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns(); end
    tryMove(4'b0010, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns();
    while (int'(eH) + 12 <= 628) begin tryMove(4'b1000, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns(); end
    tryMove(4'b1000, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns();
    while (int'(eH) >= 12) begin tryMove(4'b0100, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns(); end
    tryMove(4'b0100, 4'hF, 0, 1'b1, 1'b0, mv); releaseBtns();

    for (int e = 0; e < 150; e++) begin
      logic [3:0] b, en;
      int dly;
      b = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) en[k] = ($urandom_range(0, 7) != 0);
      dly = ($urandom_range(0, 29) == 0) ? $urandom_range(254, 256) : $urandom_range(0, 5);
      tryMove(b, en, dly, $urandom_range(0, 3) != 0, 1'($urandom), mv);
      if ($urandom_range(0, 3) == 0) begin
        cyc();
        for (int k = 0; k < 8; k++) begin
          tick = 1'b1; cyc(); tick = 1'b0; pad($urandom_range(0, 2));
        end
      end else begin
        releaseBtns();
      end
      btns = '0;
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        tick = 1'($urandom); chk_ack = 1'($urandom); chk_clear = 1'($urandom);
        cyc();
      end
      tick = 1'b0; chk_ack = 1'b0;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
